// File: rtl/scale_frame_writer_if.sv
// Pixel-stream, SRAM write-bus and status signals of scale_frame_writer.
// SCALE_WR_STAT_EN adds the drop_cnt/frame_cnt statistics outputs.
interface scale_frame_writer_if #(
  parameter int ADDR_W = 19
);
  logic [11:0]       t_width;
  logic [11:0]       t_height;
  logic [15:0]       pix_data;
  logic              pix_valid;
  logic              frame_flag;
  logic              sram_grant;
  logic              ovf_clr;
  logic              sram_req;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out;
  logic              sram_dq_oe;
  logic              sram_ce_n;
  logic              sram_we_n;
  logic              frame_done;
  logic              rd_bank;
  logic              ovf_flag;
`ifdef SCALE_WR_STAT_EN
  logic [15:0]       drop_cnt;
  logic [15:0]       frame_cnt;

  modport slave (
    input  t_width, t_height, pix_data, pix_valid, frame_flag, sram_grant, ovf_clr,
    output sram_req, sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_we_n,
    output frame_done, rd_bank, ovf_flag, drop_cnt, frame_cnt
  );
  modport master (
    output t_width, t_height, pix_data, pix_valid, frame_flag, sram_grant, ovf_clr,
    input  sram_req, sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_we_n,
    input  frame_done, rd_bank, ovf_flag, drop_cnt, frame_cnt
  );
`else
  modport slave (
    input  t_width, t_height, pix_data, pix_valid, frame_flag, sram_grant, ovf_clr,
    output sram_req, sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_we_n,
    output frame_done, rd_bank, ovf_flag
  );
  modport master (
    output t_width, t_height, pix_data, pix_valid, frame_flag, sram_grant, ovf_clr,
    input  sram_req, sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_we_n,
    input  frame_done, rd_bank, ovf_flag
  );
`endif
endinterface

// File: rtl/scale_frame_writer.sv
// Buffers scaled RGB565 pixels and writes whole frames into ping-pong SRAM banks.
// Define SCALE_WR_STAT_EN to add the drop_cnt/frame_cnt statistics counters.
module scale_frame_writer #(
  parameter int                ADDR_W     = 19,
  parameter int                FIFO_DEPTH = 16,
  parameter logic [ADDR_W-1:0] BANK1_BASE = 19'h40000,
  parameter int                WE_CYCLES  = 1
) (
  input  logic                 sram_clk,
  input  logic                 sys_rst,
  scale_frame_writer_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 1 + ADDR_W + 16;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_HOLD} state_t;

  logic              r_frame_flag_d;
  logic              r_wr_bank;
  logic              r_synced;
  logic [23:0]       r_pix_idx;
  logic              r_ovf_flag;
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_we_cnt;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [15:0]       r_sram_dq;
  logic              r_last;
  logic              r_ce_n;
  logic              r_we_n;
  logic              r_dq_oe;
  logic              r_frame_done;
  logic              r_rd_bank;

  logic              w_rise;
  logic [23:0]       w_frame_size;
  logic [23:0]       w_cur_idx;
  logic              w_cur_bank;
  logic              w_take;
  logic              w_in_frame;
  logic              w_push_try;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_drop;
  logic              w_last;
  logic [ADDR_W-1:0] w_push_addr;
  logic [ENT_W-1:0]  w_push_entry;
  logic [ENT_W-1:0]  w_head;
  logic              w_empty;
  logic              w_full;
  logic              w_can_pop;
  logic              w_done_set;

  // A pixel arriving with the frame edge already belongs to the new frame.
  assign w_rise       = bus.frame_flag & ~r_frame_flag_d;
  assign w_frame_size = 24'(bus.t_width) * 24'(bus.t_height);
  assign w_cur_idx    = w_rise ? 24'd0 : r_pix_idx;
  assign w_cur_bank   = w_rise ? ~r_wr_bank : r_wr_bank;
  assign w_take       = bus.pix_valid & (w_rise | r_synced);
  assign w_in_frame   = (w_cur_idx < w_frame_size);
  assign w_push_try   = w_take & w_in_frame;
  assign w_push       = w_push_try & ~w_full;
  assign w_ovf_set    = w_push_try & w_full;
  assign w_drop       = bus.pix_valid & ~w_push;
  assign w_last       = (w_cur_idx == w_frame_size - 24'd1);
  assign w_push_addr  = (w_cur_bank ? BANK1_BASE : '0) + ADDR_W'(w_cur_idx);
  assign w_push_entry = {w_last, w_push_addr, bus.pix_data};

  always_ff @(posedge sram_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_frame_flag_d <= 1'b0;
      r_wr_bank      <= 1'b1;
      r_synced       <= 1'b0;
      r_pix_idx      <= '0;
      r_ovf_flag     <= 1'b0;
    end else begin
      r_frame_flag_d <= bus.frame_flag;
      if (w_rise) begin
        r_wr_bank <= ~r_wr_bank;
        r_synced  <= 1'b1;
      end
      // Saturating so a long run past the frame end can never wrap back in range.
      if (w_take && (w_cur_idx != 24'hFFFFFF))
        r_pix_idx <= w_cur_idx + 24'd1;
      else if (w_rise)
        r_pix_idx <= '0;
      if (w_ovf_set)
        r_ovf_flag <= 1'b1;
      else if (bus.ovf_clr)
        r_ovf_flag <= 1'b0;
    end
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_head    = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_can_pop = ~w_empty & bus.sram_grant;

  always_ff @(posedge sram_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sram_clk) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_push_entry;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_can_pop) begin
          w_pop        = 1'b1;
          w_state_next = S_SETUP;
        end
      end
      S_SETUP: w_state_next = S_WRITE;
      S_WRITE: begin
        if (r_we_cnt == 2'(WE_CYCLES - 1)) w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (w_can_pop) begin
          w_pop        = 1'b1;
          w_state_next = S_SETUP;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_done_set = (r_state == S_WRITE) && (w_state_next == S_HOLD) && r_last;

  // Strobes are registered from the next state so they change cleanly with the state.
  always_ff @(posedge sram_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_we_cnt     <= '0;
      r_sram_addr  <= '0;
      r_sram_dq    <= '0;
      r_last       <= 1'b0;
      r_ce_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_dq_oe      <= 1'b0;
      r_frame_done <= 1'b0;
      r_rd_bank    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_we_cnt <= (r_state == S_WRITE) ? r_we_cnt + 2'd1 : 2'd0;
      if (w_pop) begin
        r_sram_addr <= w_head[ADDR_W+15:16];
        r_sram_dq   <= w_head[15:0];
        r_last      <= w_head[ENT_W-1];
      end
      r_ce_n       <= (w_state_next == S_IDLE);
      r_dq_oe      <= (w_state_next != S_IDLE);
      r_we_n       <= (w_state_next != S_WRITE);
      r_frame_done <= w_done_set;
      if (w_done_set) r_rd_bank <= (r_sram_addr >= BANK1_BASE);
    end
  end

  assign bus.sram_req    = ~w_empty | (r_state != S_IDLE);
  assign bus.sram_addr   = r_sram_addr;
  assign bus.sram_dq_out = r_sram_dq;
  assign bus.sram_dq_oe  = r_dq_oe;
  assign bus.sram_ce_n   = r_ce_n;
  assign bus.sram_we_n   = r_we_n;
  assign bus.frame_done  = r_frame_done;
  assign bus.rd_bank     = r_rd_bank;
  assign bus.ovf_flag    = r_ovf_flag;

`ifdef SCALE_WR_STAT_EN
  logic [15:0] r_drop_cnt;
  logic [15:0] r_frame_cnt;

  always_ff @(posedge sram_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_drop_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      // A drop in the clearing cycle still counts, mirroring the flag priority.
      if (bus.ovf_clr)
        r_drop_cnt <= {15'd0, w_drop};
      else if (w_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_done_set) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.frame_cnt = r_frame_cnt;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif
endmodule
